// File: rtl/mcu_spi.sv
// mcu_spi: SPI slave front end routing MCU link bytes to the sys/HID/OSD/SD clients.
//   Oversamples the asynchronous MCU SPI lines (mode 0, MSB first) in the clk domain.
//   The first byte of a frame selects target 0..3; each following byte is delivered as a
//   one-cycle strobe on that target (mcu_start marks the first payload byte), and the
//   target's reply byte is shifted back out on MISO.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   spi_io_ss/clk/din           raw MCU SS (active low), SCK, MOSI
//   spi_io_dout                 MISO
//   mcu_start, mcu_dout         first-payload flag and last received payload byte
//   mcu_*_strobe, mcu_*_din     per-target byte strobes and reply bytes (sys, hid, osd, sdc)
// Optional build macro: MCU_SPI_TIMEOUT_EN aborts a frame whose SCK stalls for
//   TIMEOUT_CYCLES clk cycles while SS is low.
module mcu_spi #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_io_ss,
   input  logic       spi_io_clk,
   input  logic       spi_io_din,
   output logic       spi_io_dout,
   output logic       mcu_start,
   output logic [7:0] mcu_dout,
   output logic       mcu_sys_strobe,
   output logic       mcu_hid_strobe,
   output logic       mcu_osd_strobe,
   output logic       mcu_sdc_strobe,
   input  logic [7:0] mcu_sys_din,
   input  logic [7:0] mcu_hid_din,
   input  logic [7:0] mcu_osd_din,
   input  logic [7:0] mcu_sdc_din
);
   typedef enum logic [2:0] {IDLE, TARGET, FIRST, PAYLOAD, DISCARD} state_t;
   state_t state, state_next;
   logic [2:0] ss_sync, sck_sync;
   logic [1:0] mosi_sync;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx, din_sel;
   logic [3:0] stb;
   logic [1:0] target, settle;
   logic byte_done, load1, load2, timeout;
   logic ss_high, ss_fall, sck_rise, sck_fall, active, deliver;
   assign ss_high = ss_sync[1];
   assign ss_fall = ss_sync[2] & ~ss_sync[1];
   assign sck_rise = sck_sync[1] & ~sck_sync[2];
   assign sck_fall = ~sck_sync[1] & sck_sync[2];
   assign active = state == TARGET || state == FIRST || state == PAYLOAD;
   assign deliver = byte_done && !ss_high && (state == FIRST || state == PAYLOAD);
   assign din_sel = target == 2'd0 ? mcu_sys_din : target == 2'd1 ? mcu_hid_din :
                    target == 2'd2 ? mcu_osd_din : mcu_sdc_din;
   assign spi_io_dout = active & ~ss_high & tx[7];
   assign {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe} = stb;
`ifdef MCU_SPI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] to_cnt;
   assign timeout = to_cnt == TO_MAX;
   always_ff @(posedge clk)
      if (reset || ss_high || sck_rise || sck_fall) to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + 1'b1;
`else
   assign timeout = 1'b0;
`endif
   // After reset the synchronisers hold idle-high SS for two cycles; settle keeps
   // DISCARD from mistaking that for a real SS-high and joining a frame mid-way.
   always_comb begin
      state_next = state;
      if (state == DISCARD) state_next = (ss_high && settle == 2'd0) ? IDLE : DISCARD;
      else if (ss_high) state_next = IDLE;
      else if (timeout && active) state_next = DISCARD;
      else if (state == IDLE && ss_fall) state_next = TARGET;
      else if (state == TARGET && byte_done) state_next = rx_shift < 8'd4 ? FIRST : DISCARD;
      else if (state == FIRST && byte_done) state_next = PAYLOAD;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DISCARD;
         ss_sync <= 3'b111;
         sck_sync <= 3'b000;
         mosi_sync <= 2'b00;
         settle <= 2'd2;
         bit_cnt <= 3'd0;
         rx_shift <= 8'h00;
         byte_done <= 1'b0;
         stb <= 4'b0;
         mcu_start <= 1'b0;
         mcu_dout <= 8'h00;
         target <= 2'd0;
         load1 <= 1'b0;
         load2 <= 1'b0;
         tx <= 8'h00;
      end else begin
         state <= state_next;
         ss_sync <= {ss_sync[1:0], spi_io_ss};
         sck_sync <= {sck_sync[1:0], spi_io_clk};
         mosi_sync <= {mosi_sync[0], spi_io_din};
         settle <= settle == 2'd0 ? 2'd0 : settle - 2'd1;
         bit_cnt <= (!active || ss_high) ? 3'd0 : sck_rise ? bit_cnt + 3'd1 : bit_cnt;
         rx_shift <= sck_rise ? {rx_shift[6:0], mosi_sync[1]} : rx_shift;
         byte_done <= active && !ss_high && !timeout && sck_rise && bit_cnt == 3'd7;
         stb <= deliver ? 4'b0001 << target : 4'b0000;
         mcu_start <= deliver && state == FIRST;
         mcu_dout <= deliver ? rx_shift : mcu_dout;
         target <= (state == TARGET && byte_done) ? rx_shift[1:0] : target;
         // Reply is loaded two cycles after the strobe so the client has a cycle to update it.
         load1 <= byte_done && active && !ss_high;
         load2 <= load1;
         // The falling edge after the 8th rise (counter wrapped to 0) must not shift.
         tx <= state == IDLE ? 8'h00 : load2 ? din_sel :
               (sck_fall && bit_cnt != 3'd0) ? {tx[6:0], 1'b0} : tx;
      end
   end
endmodule

// File: tb/tb_mcu_spi.sv
// tb_mcu_spi: directed self-checking bench for mcu_spi.
module tb_mcu_spi;
   logic clk = 0, reset = 1, ss = 1, sck = 0, mosi = 0;
   logic miso, start;
   logic [7:0] dout;
   logic s_sys, s_hid, s_osd, s_sdc;
   logic [7:0] sys_din = 8'hA5, hid_din = 8'h3C, osd_din = 8'h5A, sdc_din = 8'hC3;
   int vectors = 0, miscompares = 0;
   typedef struct packed {logic [3:0] stb; logic st; logic [7:0] d;} rec_t;
   rec_t q[$];
   logic [7:0] r;

   mcu_spi #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .spi_io_ss(ss), .spi_io_clk(sck), .spi_io_din(mosi),
      .spi_io_dout(miso), .mcu_start(start), .mcu_dout(dout),
      .mcu_sys_strobe(s_sys), .mcu_hid_strobe(s_hid), .mcu_osd_strobe(s_osd),
      .mcu_sdc_strobe(s_sdc), .mcu_sys_din(sys_din), .mcu_hid_din(hid_din),
      .mcu_osd_din(osd_din), .mcu_sdc_din(sdc_din));

   always #5 clk = ~clk;

   always @(negedge clk)
      if ({s_sdc, s_osd, s_hid, s_sys} != 4'b0) q.push_back({{s_sdc, s_osd, s_hid, s_sys}, start, dout});

   function automatic rec_t get(input int i);
      return q.size() > i ? q[i] : '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         repeat (8) @(negedge clk);
         rx = {rx[6:0], miso};
         sck = 1;
         repeat (8) @(negedge clk);
         sck = 0;
      end
   endtask

   task automatic ss_low();
      @(negedge clk);
      ss = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic ss_up();
      repeat (4) @(negedge clk);
      ss = 1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      #1;
      chk("rst_strobes", {s_sys, s_hid, s_osd, s_sdc}, 4'b0);
      chk("rst_start", start, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_miso", miso, 1'b0);
      repeat (4) @(negedge clk);

      // Frame 1: sys, two payload bytes
      q.delete();
      ss_low();
      send_bits(8'h00, 8, r); chk("f1_miso0", r, 8'h00);
      send_bits(8'h05, 8, r); chk("f1_miso1", r, 8'hA5);
      send_bits(8'h01, 8, r); chk("f1_miso2", r, 8'hA5);
      ss_up();
      chk("f1_count", q.size(), 2);
      chk("f1_rec0", get(0), {4'b0001, 1'b1, 8'h05});
      chk("f1_rec1", get(1), {4'b0001, 1'b0, 8'h01});
      chk("f1_idle_miso", miso, 1'b0);

      // Frame 2: sdc, exact strobe latency
      q.delete();
      ss_low();
      send_bits(8'h03, 8, r);
      send_bits(8'h42, 7, r);
      mosi = 0;
      repeat (8) @(negedge clk);
      sck = 1;
      repeat (3) @(posedge clk);
      #1 chk("f2_n2_sdc", s_sdc, 1'b0);
      @(posedge clk);
      #1 chk("f2_n3_sdc", s_sdc, 1'b1);
      chk("f2_n3_dout", dout, 8'h42);
      chk("f2_n3_start", start, 1'b1);
      @(posedge clk);
      #1 chk("f2_n4_sdc", s_sdc, 1'b0);
      chk("f2_n4_start", start, 1'b0);
      chk("f2_hold_dout", dout, 8'h42);
      repeat (6) @(negedge clk);
      sck = 0;
      ss_up();
      chk("f2_count", q.size(), 1);
      chk("f2_rec0", get(0), {4'b1000, 1'b1, 8'h42});

      // Frame 3: invalid target discards
      q.delete();
      ss_low();
      send_bits(8'h07, 8, r); chk("f3_miso0", r, 8'h00);
      send_bits(8'h11, 8, r); chk("f3_miso1", r, 8'h00);
      send_bits(8'h22, 8, r); chk("f3_miso2", r, 8'h00);
      ss_up();
      chk("f3_count", q.size(), 0);

      // Frame 4: aborted partial byte, then hid frame
      q.delete();
      ss_low();
      send_bits(8'h02, 8, r);
      send_bits(8'hFF, 5, r);
      ss_up();
      chk("f4_partial", q.size(), 0);
      ss_low();
      send_bits(8'h01, 8, r);
      send_bits(8'h33, 8, r); chk("f4_miso1", r, 8'h3C);
      ss_up();
      chk("f4_count", q.size(), 1);
      chk("f4_rec0", get(0), {4'b0010, 1'b1, 8'h33});

      // Frame 5: reset mid-frame with SS low
      q.delete();
      ss_low();
      send_bits(8'h00, 8, r);
      send_bits(8'h80, 4, r);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      send_bits(8'h00, 8, r);
      send_bits(8'h09, 8, r);
      chk("f5_ignored", q.size(), 0);
      chk("f5_miso", r, 8'h00);
      ss_up();
      ss_low();
      send_bits(8'h00, 8, r);
      send_bits(8'h04, 8, r);
      ss_up();
      chk("f5_count", q.size(), 1);
      chk("f5_rec0", get(0), {4'b0001, 1'b1, 8'h04});

`ifdef MCU_SPI_TIMEOUT_EN
      // Frame 6: SCK stall triggers timeout
      q.delete();
      ss_low();
      send_bits(8'h00, 8, r);
      send_bits(8'hA0, 4, r);
      repeat (100) @(negedge clk);
      send_bits(8'hAB, 8, r);
      send_bits(8'hC0, 4, r);
      chk("f6_stalled", q.size(), 0);
      ss_up();
      ss_low();
      send_bits(8'h00, 8, r);
      send_bits(8'h04, 8, r);
      ss_up();
      chk("f6_count", q.size(), 1);
      chk("f6_rec0", get(0), {4'b0001, 1'b1, 8'h04});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
